spio_spinn2aer_mapper_buf: RTL and testbench



---
 rtl/spio_spinn2aer_mapper_buf.sv | 187 ++++++++++++++++++
 tb/tb_spio_spinn2aer_mapper_buf.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/spio_spinn2aer_mapper_buf.sv
// SpiNNaker packet to AER output mapper.
// Incoming packets are filtered on their routing key, and the AER slice of each
// accepted packet is queued in a small FIFO. A four-phase output FSM drains the
// FIFO towards an asynchronous AER device. The device acknowledge is brought
// into the clk domain through a flop synchroniser. Filtered packets are counted.
`timescale 1ns/1ps
module spio_spinn2aer_mapper_buf #(
    parameter int          PKT_BITS    = 72,
    parameter int          AER_BITS    = 16,
    parameter int          KEY_LSB     = 8,
    parameter logic [31:0] KEY_MASK    = 32'h0000_0000,
    parameter logic [31:0] KEY_MATCH   = 32'h0000_0000,
    parameter int          FIFO_LOG2   = 2,
    parameter int          SYNC_STAGES = 2,
    parameter int          CNT_BITS    = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [PKT_BITS-1:0]  opkt_data,
    input  logic                 opkt_vld,
    output logic                 opkt_rdy,
    output logic [AER_BITS-1:0]  oaer_data,
    output logic                 oaer_req,
    input  logic                 oaer_ack,
    output logic [CNT_BITS-1:0]  drop_cnt,
    output logic [FIFO_LOG2:0]   fifo_level
);

    localparam int                 DEPTH    = 1 << FIFO_LOG2;
    localparam logic [FIFO_LOG2:0] FULL_LVL = (FIFO_LOG2 + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    // FIFO storage and pointers
    logic [AER_BITS-1:0]    mem_q [DEPTH];
    logic [FIFO_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
    logic [FIFO_LOG2-1:0]   rd_ptr_q, rd_ptr_d;
    logic [FIFO_LOG2:0]     level_q, level_d;

    // Filter / drop counter
    logic [CNT_BITS-1:0]    drop_cnt_q, drop_cnt_d;
    logic [31:0]            key;
    logic                   key_pass;
    logic                   xfer;
    logic                   push;
    logic                   pop;
    logic                   fifo_empty;

    // Ack synchroniser
    logic [SYNC_STAGES-1:0] ack_sync_q, ack_sync_d;
    logic                   ack_s;

    // Output FSM
    state_t                 state_q, state_d;
    logic                   req_q, req_d;
    logic [AER_BITS-1:0]    data_q, data_d;

    // Only the routing key and the AER slice carry meaning; the rest is ignored.
    logic                   unused_pkt;
    assign unused_pkt = ^opkt_data;

    assign key        = opkt_data[39:8];
    assign key_pass   = ((key & KEY_MASK) == KEY_MATCH);
    assign opkt_rdy   = (level_q != FULL_LVL);
    assign xfer       = opkt_vld & opkt_rdy;
    assign push       = xfer & key_pass;
    assign fifo_empty = (level_q == '0);
    assign ack_s      = ack_sync_q[SYNC_STAGES-1];

    assign oaer_data  = data_q;
    assign oaer_req   = req_q;
    assign drop_cnt   = drop_cnt_q;
    assign fifo_level = level_q;

    // Output FSM next-state: pop only from IDLE, data latched on IDLE->REQ
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        data_d  = data_q;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_d = 1'b1;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    data_d  = mem_q[rd_ptr_q];
                    req_d   = 1'b0;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                req_d = 1'b0;
                if (!ack_s) begin
                    req_d   = 1'b1;
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                req_d = 1'b1;
                if (ack_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                req_d   = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    // FIFO pointer / occupancy next-state; a simultaneous push and pop cancel out
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    // Drop counter next-state, saturating at all-ones
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (xfer && !key_pass && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + 1'b1;
        end
    end

    // Synchroniser shift: stage 0 samples the pin
    always_comb begin
        ack_sync_d    = ack_sync_q;
        ack_sync_d[0] = oaer_ack;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            ack_sync_d[i] = ack_sync_q[i-1];
        end
    end

    // FIFO data array; contents need no reset since pointers gate every read
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= opkt_data[KEY_LSB+AER_BITS-1:KEY_LSB];
        end
    end

    // FIFO control, drop counter and synchroniser state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            drop_cnt_q <= '0;
            ack_sync_q <= '1;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            drop_cnt_q <= drop_cnt_d;
            ack_sync_q <= ack_sync_d;
        end
    end

    // Output FSM registers; reset raises req at once, abandoning any handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b1;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: tb/tb_spio_spinn2aer_mapper_buf.sv
// Directed bench for spio_spinn2aer_mapper_buf with a scoreboard queue of
// expected AER events and a behavioural four-phase AER device.
`timescale 1ns/1ps
module tb_spio_spinn2aer_mapper_buf;

    localparam int          CNT_BITS = 2;
    localparam logic [31:0] MASK     = 32'hFFFF_0000;
    localparam logic [31:0] MATCH    = 32'h1234_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [71:0] opkt_data = '0;
    logic        opkt_vld = 1'b0;
    logic        opkt_rdy;
    logic [15:0] oaer_data;
    logic        oaer_req;
    logic        oaer_ack;
    logic [CNT_BITS-1:0] drop_cnt;
    logic [2:0]  fifo_level;

    int total = 0;
    int bad   = 0;
    logic [15:0] exp_q [$];

    // AER device: manual control or automatic responder
    logic man_ack = 1'b1;
    logic dev_ack = 1'b1;
    logic dev_en  = 1'b0;
    int   dev_st  = 0;
    int   dev_cnt = 0;
    int   dev_dly = 1;
    assign oaer_ack = dev_en ? dev_ack : man_ack;

    always #5 clk = ~clk;

    spio_spinn2aer_mapper_buf #(
        .PKT_BITS(72), .AER_BITS(16), .KEY_LSB(8),
        .KEY_MASK(MASK), .KEY_MATCH(MATCH),
        .FIFO_LOG2(2), .SYNC_STAGES(2), .CNT_BITS(CNT_BITS)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .opkt_data(opkt_data), .opkt_vld(opkt_vld), .opkt_rdy(opkt_rdy),
        .oaer_data(oaer_data), .oaer_req(oaer_req), .oaer_ack(oaer_ack),
        .drop_cnt(drop_cnt), .fifo_level(fifo_level)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Compare the event currently presented against the scoreboard head
    task automatic chk_evt();
        logic [15:0] e;
        if (exp_q.size() == 0) begin
            chk("evt_extra", {16'h0, oaer_data}, 32'hFFFF_FFFF);
        end else begin
            e = exp_q.pop_front();
            chk("evt_data", {16'h0, oaer_data}, {16'h0, e});
        end
    endtask

    always @(negedge clk) begin
        if (dev_en) begin
            case (dev_st)
                0: if (oaer_req == 1'b0) begin chk_evt(); dev_cnt = 0; dev_st = 1; end
                1: if (dev_cnt >= dev_dly) begin dev_ack = 1'b0; dev_st = 2; end else dev_cnt++;
                2: if (oaer_req == 1'b1) begin dev_cnt = 0; dev_st = 3; end
                3: if (dev_cnt >= dev_dly) begin dev_ack = 1'b1; dev_st = 0; end else dev_cnt++;
                default: dev_st = 0;
            endcase
        end else begin
            dev_st  = 0;
            dev_ack = 1'b1;
        end
    end

    function automatic logic [71:0] mk(input logic [31:0] key);
        return {32'h0, key, 8'h00};
    endfunction

    // Present a packet; returns #1 after the transfer edge
    task automatic send(input logic [31:0] key);
        int n = 0;
        @(negedge clk);
        opkt_data = mk(key);
        opkt_vld  = 1'b1;
        while (!opkt_rdy && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!opkt_rdy) begin
            chk("send_timeout", 32'd0, 32'd1);
        end else begin
            if ((key & MASK) == MATCH) exp_q.push_back(key[15:0]);
            @(posedge clk);
            #1;
        end
        opkt_vld = 1'b0;
    endtask

    // Wait until every expected event has been delivered and the device is idle
    task automatic drain();
        int n = 0;
        while (!(exp_q.size() == 0 && dev_st == 0 && oaer_req == 1'b1) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_left", exp_q.size(), 32'd0);
        repeat (8) @(negedge clk);
        chk("drain_level", {29'h0, fifo_level}, 32'd0);
    endtask

    initial begin
        bit seen_low;

        // Reset values
        #12;
        chk("rst_rdy",   {31'h0, opkt_rdy}, 32'd1);
        chk("rst_req",   {31'h0, oaer_req}, 32'd1);
        chk("rst_data",  {16'h0, oaer_data}, 32'd0);
        chk("rst_drop",  {30'h0, drop_cnt}, 32'd0);
        chk("rst_level", {29'h0, fifo_level}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single event latency and handshake timing
        opkt_data = mk(32'h1234_A5C3);
        opkt_vld  = 1'b1;
        @(posedge clk); #1;
        opkt_vld  = 1'b0;
        chk("lat_level1", {29'h0, fifo_level}, 32'd1);
        chk("lat_req_n",  {31'h0, oaer_req}, 32'd1);
        @(posedge clk); #1;
        chk("lat_req_n1", {31'h0, oaer_req}, 32'd0);
        chk("lat_data",   {16'h0, oaer_data}, 32'h0000_A5C3);
        chk("lat_level0", {29'h0, fifo_level}, 32'd0);
        repeat (3) @(negedge clk);
        man_ack = 1'b0;
        repeat (2) @(posedge clk); #1;
        chk("ack_req_hold", {31'h0, oaer_req}, 32'd0);
        @(posedge clk); #1;
        chk("ack_req_rise", {31'h0, oaer_req}, 32'd1);
        repeat (3) @(negedge clk);
        man_ack = 1'b1;
        repeat (4) @(posedge clk); #1;
        chk("ack_idle_req",   {31'h0, oaer_req}, 32'd1);
        chk("ack_idle_level", {29'h0, fifo_level}, 32'd0);

        // Stalled device: one in flight plus four stored, input blocked
        for (int i = 0; i < 5; i++) send(32'h1234_0100 + i);
        @(negedge clk);
        chk("stall_rdy",   {31'h0, opkt_rdy}, 32'd0);
        chk("stall_level", {29'h0, fifo_level}, 32'd4);
        chk("stall_req",   {31'h0, oaer_req}, 32'd0);
        dev_dly = 1;
        dev_en  = 1'b1;
        send(32'h1234_0105);
        drain();

        // Key filter and saturating drop counter
        send(32'h1234_0001);
        send(32'h5678_0002);
        chk("filt_drop1", {30'h0, drop_cnt}, 32'd1);
        send(32'h5678_0003);
        chk("filt_drop2", {30'h0, drop_cnt}, 32'd2);
        send(32'h0000_0004);
        chk("filt_drop3", {30'h0, drop_cnt}, 32'd3);
        send(32'hFFFF_0005);
        chk("filt_sat4", {30'h0, drop_cnt}, 32'd3);
        send(32'h1235_0006);
        chk("filt_sat5", {30'h0, drop_cnt}, 32'd3);
        drain();

        // Push and pop on the same edge with two stored events
        dev_en  = 1'b0;
        man_ack = 1'b1;
        send(32'h1234_0200);
        send(32'h1234_0201);
        send(32'h1234_0202);
        chk("pp_level_pre", {29'h0, fifo_level}, 32'd2);
        chk_evt();
        @(negedge clk); man_ack = 1'b0;
        repeat (3) @(posedge clk); #1;
        chk("pp_req_hi", {31'h0, oaer_req}, 32'd1);
        @(negedge clk); man_ack = 1'b1;
        repeat (3) @(posedge clk);
        send(32'h1234_0203);
        chk("pp_level_same", {29'h0, fifo_level}, 32'd2);
        chk("pp_req_lo",     {31'h0, oaer_req}, 32'd0);
        chk_evt();
        @(negedge clk); man_ack = 1'b0;
        repeat (3) @(posedge clk); #1;
        @(negedge clk); man_ack = 1'b1;
        dev_dly = 0;
        dev_en  = 1'b1;
        // Stream across several pointer wraps
        for (int i = 0; i < 12; i++) send(32'h1234_1000 + i);
        drain();

        // Reset during REQ with three queued
        dev_en  = 1'b0;
        man_ack = 1'b1;
        for (int i = 0; i < 4; i++) send(32'h1234_0300 + i);
        chk("rq_level", {29'h0, fifo_level}, 32'd3);
        chk("rq_req",   {31'h0, oaer_req}, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rq_async_req",   {31'h0, oaer_req}, 32'd1);
        chk("rq_async_level", {29'h0, fifo_level}, 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        seen_low = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (oaer_req == 1'b0) seen_low = 1'b1;
        end
        chk("rq_no_stale", {31'h0, seen_low}, 32'd0);
        chk("rq_rdy",      {31'h0, opkt_rdy}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog
    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
